// File: rtl/matmul_job_sched_pkg.sv
// rtl/matmul_job_sched_pkg.sv - shared state encodings, width helper and default watchdog limit
package matmul_job_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 64;

  // Bits needed to index 'value' distinct items (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_job_sched_rr_pick.sv
// rtl/matmul_job_sched_rr_pick.sv - rotate-priority-rotate arbiter: first request at or after ptr_i
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] id_o
);

  localparam logic [IW:0] NV = N[IW:0];

  logic [N-1:0]  rot;
  logic [IW:0]   cand;
  logic [IW:0]   sum;
  logic [IW-1:0] off;
  logic          found;

  // rot[k] is the request k places after the pointer.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + k[IW:0];
      if (cand >= NV) cand = cand - NV;
      rot[k] = req_i[cand[IW-1:0]];
    end
  end

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k[IW-1:0];
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    id_o     = sum[IW-1:0];
    valid_o  = found;
    onehot_o = '0;
    onehot_o[sum[IW-1:0]] = found;
  end

endmodule

// File: rtl/matmul_job_sched.sv
// rtl/matmul_job_sched.sv - round-robin job scheduler sharing one systolic multiplier
// Define MATMUL_WDOG_EN to add the RUN-state watchdog that aborts hung jobs.
module matmul_job_sched
  import matmul_job_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rsp_ack,
  input  logic               mm_done,
  output logic               mm_clr,
  output logic               mm_start,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_err,
  output logic               busy,
  output logic [CNT_W-1:0]   jobs_done
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               mm_clr_q, mm_clr_d;
  logic               mm_start_q, mm_start_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   jobs_q, jobs_d;
  logic               err_now;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_id;
  logic               ack_own;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_gnt),
    .id_o     (pick_id)
  );

  // Only the owner's ack matters; gnt_q is one-hot on the owner.
  assign ack_own = |(rsp_ack & gnt_q);

`ifdef MATMUL_WDOG_EN
  localparam int              WDOG_W    = clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_now = err_q;
  assign rsp_err = err_q;
`else
  assign err_now = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    mm_clr_d    = 1'b0;
    mm_start_d  = 1'b0;
    rsp_valid_d = rsp_valid_q;
    jobs_d      = jobs_q;
`ifdef MATMUL_WDOG_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          gnt_id_d = pick_id;
          mm_clr_d = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mm_start_d = 1'b1;
        state_d    = S_START;
      end
      S_START: begin
`ifdef MATMUL_WDOG_EN
        wdog_d  = '0;
`endif
        state_d = S_RUN;
      end
      S_RUN: begin
        // A done pulse on the timeout cycle is still a normal completion.
        if (mm_done) begin
          rsp_valid_d = gnt_q;
          state_d     = S_HOLD;
        end
`ifdef MATMUL_WDOG_EN
        else if (wdog_q == WDOG_LAST) begin
          rsp_valid_d = gnt_q;
          err_d       = 1'b1;
          mm_clr_d    = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (ack_own) begin
          rsp_valid_d = '0;
          gnt_d       = '0;
          rr_ptr_d    = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
          if (!err_now) jobs_d = jobs_q + 1'b1;
`ifdef MATMUL_WDOG_EN
          err_d       = 1'b0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      mm_clr_q    <= 1'b0;
      mm_start_q  <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      mm_clr_q    <= mm_clr_d;
      mm_start_q  <= mm_start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      jobs_q      <= jobs_d;
    end
  end

  assign mm_clr    = mm_clr_q;
  assign mm_start  = mm_start_q;
  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;
  assign jobs_done = jobs_q;

endmodule

// File: tb/tb_matmul_job_sched.sv
// tb/tb_matmul_job_sched.sv - randomized self-checking bench with a job-timeline reference model
module tb_matmul_job_sched;

  localparam int N = 4;
`ifdef MATMUL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] rsp_ack;
  logic         mm_done;
  logic         mm_clr;
  logic         mm_start;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic [N-1:0] rsp_valid;
  logic         rsp_err;
  logic         busy;
  logic [15:0]  jobs_done;

  logic stub_done;
  logic stray_done;
  int   lat;
  int   stub_cnt;

  int d_checks = 0, d_errs = 0;
  int m_checks = 0, m_errs = 0;

  assign mm_done = stub_done | stray_done;

  always #5 clk = ~clk;

  matmul_job_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rsp_ack   (rsp_ack),
    .mm_done   (mm_done),
    .mm_clr    (mm_clr),
    .mm_start  (mm_start),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  // Multiplier stub: done appears in RUN cycle 'lat' after the start pulse; lat==0 never finishes.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt  = 0;
      stub_done = 1'b0;
    end else begin
      stub_done = 1'b0;
      if (mm_start && lat > 0) stub_cnt = lat;
      else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) stub_done = 1'b1;
      end
    end
  end

  // Reference: owner, age since grant, result-ready flag, pointer and job count.
  int m_owner, m_age, m_rc, m_ptr, m_jobs;
  bit m_done, m_err, m_abort;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_age = 0; m_rc = 0; m_ptr = 0; m_jobs = 0;
      m_done = 0; m_err = 0; m_abort = 0;
    end else begin
      m_abort = 0;
      if (m_owner < 0) begin
        if (req != 0) begin
          for (int k = 0; k < N; k++)
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_age = 0; m_rc = 0; m_done = 0; m_err = 0;
        end
      end else begin
        if (m_done) begin
          if (rsp_ack[m_owner]) begin
            if (!m_err) m_jobs = (m_jobs + 1) % 65536;
            m_ptr = (m_owner + 1) % N;
            m_owner = -1; m_done = 0; m_err = 0;
          end
        end else if (m_age >= 2) begin
          m_rc++;
          if (mm_done) m_done = 1;
          else if (WDOG && m_rc == TIMEOUT) begin
            m_done = 1; m_err = 1; m_abort = 1;
          end
        end
        m_age++;
      end
    end
  end

  logic [29:0] exp_v, act_v;
  always @(negedge clk) begin
    logic [3:0] e_gnt, e_val;
    logic [1:0] e_id, a_id;
    logic       e_clr, e_start;
    e_gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    e_val   = (m_owner >= 0 && m_done) ? e_gnt : 4'b0;
    e_id    = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
    a_id    = (m_owner >= 0) ? gnt_id : 2'b0;
    e_clr   = (m_owner >= 0 && m_age == 0) || m_abort;
    e_start = (m_owner >= 0 && m_age == 1);
    exp_v = {e_gnt, e_id, e_clr, e_start, e_val, m_err, (m_owner >= 0), 16'(m_jobs)};
    act_v = {gnt, a_id, mm_clr, mm_start, rsp_valid, rsp_err, busy, jobs_done};
    m_checks++;
    if (act_v !== exp_v) begin
      m_errs++;
      if (m_errs < 30) $display("FAIL model_cycle t=%0t act=%h exp=%h", $time, act_v, exp_v);
    end
    if (mm_clr && mm_start) begin
      m_errs++;
      $display("FAIL clr_start_overlap t=%0t act=11 exp=not both", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    d_checks++;
    if (act !== exp) begin
      d_errs++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int idx, input int bound, output int n);
    n = 0;
    while (!rsp_valid[idx] && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(rsp_valid[idx]), 32'd1);
  endtask

  task automatic wait_gnt(input int bound);
    int n;
    n = 0;
    while (gnt == 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_gnt", 32'(gnt != 0), 32'd1);
  endtask

  task automatic ack(input int idx);
    rsp_ack = 4'(1 << idx);
    step(1);
    rsp_ack = '0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; rsp_ack = '0; stray_done = 1'b0; lat = 30;
    step(3);
    chk("reset_outputs", {gnt, gnt_id, mm_clr, mm_start, rsp_valid, rsp_err, busy, jobs_done}, 32'd0);
    rst = 1'b0;
    step(1);

    // Single job on requester 2, done 30 cycles after start.
    req = 4'b0100;
    step(1);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_gnt_id", gnt_id, 2);
    chk("single_clr", {mm_clr, mm_start}, 2'b10);
    step(1);
    chk("single_start", {mm_clr, mm_start}, 2'b01);
    wait_valid(2, 100, n);
    chk("single_latency", n, 31);
    step(5);
    chk("single_hold", rsp_valid, 4'b0100);
    ack(2);
    chk("single_after_ack", {rsp_valid, busy, jobs_done}, {4'b0, 1'b0, 16'd1});
    step(1);
    chk("single_regrant", {busy, gnt}, {1'b1, 4'b0100});
    req = '0;
    wait_valid(2, 100, n);
    ack(2);
    chk("single_jobs2", jobs_done, 2);

    // Reset mid-RUN; the owner would have been 3.
    lat = 0;
    req = 4'b1000;
    step(6);
    chk("pre_reset_owner", gnt_id, 3);
    #1 rst = 1'b1;
    #1 chk("async_reset", {gnt, gnt_id, mm_clr, mm_start, rsp_valid, rsp_err, busy, jobs_done}, 32'd0);
    step(1);
    rst = 1'b0;

    // Fairness from rr_ptr=0.
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      lat = $urandom_range(1, 40);
      wait_gnt(20);
      chk("fair_order", gnt_id, j % 4);
      wait_valid(j % 4, 100, n);
      if (j == 7) req = '0;
      ack(j % 4);
    end
    chk("fair_jobs", jobs_done, 8);

    // Non-owner ack and stray done while HOLD.
    req = 4'b0010;
    wait_gnt(20);
    req = '0;
    wait_valid(1, 100, n);
    rsp_ack = 4'b0001; stray_done = 1'b1;
    step(1);
    rsp_ack = '0; stray_done = 1'b0;
    step(1);
    chk("nonowner_hold", {rsp_valid, busy, gnt_id, jobs_done}, {4'b0010, 1'b1, 2'd1, 16'd8});
    ack(1);
    chk("nonowner_jobs", jobs_done, 9);

    // Withdrawn request, with an ack during RUN that must be ignored.
    lat = 20;
    req = 4'b0001;
    step(1);
    req = '0;
    step(2);
    rsp_ack = 4'b0001;
    step(1);
    rsp_ack = '0;
    wait_valid(0, 100, n);
    step(3);
    chk("withdrawn_hold", {rsp_valid, busy}, {4'b0001, 1'b1});
    ack(0);
    chk("withdrawn_idle", {rsp_valid, busy, jobs_done}, {4'b0, 1'b0, 16'd10});

    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    step(1);
    chk("idle_stray_done", {busy, jobs_done}, {1'b0, 16'd10});

`ifdef MATMUL_WDOG_EN
    for (int pass = 0; pass < 2; pass++) begin
      lat = (pass == 0) ? 0 : 64;
      req = 4'b0001;
      step(1);
      req = '0;
      step(1);
      chk("wdog_start", mm_start, 1);
      wait_valid(0, 200, n);
      chk("wdog_latency", n, 65);
      chk("wdog_err", rsp_err, (pass == 0) ? 1 : 0);
      chk("wdog_clr", mm_clr, (pass == 0) ? 1 : 0);
      ack(0);
      chk("wdog_jobs", jobs_done, (pass == 0) ? 10 : 11);
    end
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      rsp_ack = '0;
      if ((|rsp_valid) && $urandom_range(0, 3) == 0) rsp_ack = rsp_valid;
      if ($urandom_range(0, 7) == 0) rsp_ack = rsp_ack | 4'($urandom);
      stray_done = ($urandom_range(0, 40) == 0);
      lat = WDOG ? $urandom_range(0, 80) : $urandom_range(1, 40);
    end
    req = '0; rsp_ack = '0; stray_done = 1'b0;
    step(2);

    d_checks += m_checks;
    d_errs   += m_errs;
    $display("CHECKS %0d ERRORS %0d", d_checks, d_errs);
    $finish;
  end

endmodule
